// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions for the burst bridge.
// Holds burst/response encodings, the FSM state types of both bridge
// paths, and the per-beat address advance used by the descriptor block.
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_BRESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_WAIT, R_OUT} rd_state_e;

  // WRAP steps like INCR; the reserved encoding holds the address like FIXED.
  // The caller truncates the result, which gives the modulo-2^addr_width wrap.
  function automatic logic [31:0] axi_next_addr(input logic [31:0] addr,
                                                input logic [2:0]  size,
                                                input logic [1:0]  burst);
    logic [31:0] nxt;
    nxt = addr;
    if (burst == BURST_INCR || burst == BURST_WRAP) nxt = addr + (32'd1 << size);
    return nxt;
  endfunction

endpackage

// File: rtl/axi4_lite_burst_ctl.sv
// Burst descriptor block, one instance per bridge path.
// Ports: load_i captures the AXI4 descriptor and clears the beat counter;
// adv_i steps the address and beat counter after a completed beat.
// addr_o/prot_o/id_o present the current beat; last_o flags counter == len.
module axi4_lite_burst_ctl
  import axi4_pkg::*;
#(
  parameter int addr_width = 5,
  parameter int id_width   = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  load_i,
  input  logic                  adv_i,
  input  logic [addr_width-1:0] addr_i,
  input  logic [7:0]            len_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  input  logic [2:0]            prot_i,
  input  logic [id_width-1:0]   id_i,
  output logic [addr_width-1:0] addr_o,
  output logic [2:0]            prot_o,
  output logic [id_width-1:0]   id_o,
  output logic                  last_o
);

  logic [addr_width-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d, cnt_q, cnt_d;
  logic [2:0]            size_q, size_d, prot_q, prot_d;
  logic [1:0]            burst_q, burst_d;
  logic [id_width-1:0]   id_q, id_d;

  assign last_o = (cnt_q == len_q);
  assign addr_o = addr_q;
  assign prot_o = prot_q;
  assign id_o   = id_q;

  always_comb begin
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    prot_d  = prot_q;
    burst_d = burst_q;
    id_d    = id_q;
    if (load_i) begin
      addr_d  = addr_i;
      len_d   = len_i;
      cnt_d   = '0;
      size_d  = size_i;
      prot_d  = prot_i;
      burst_d = burst_i;
      id_d    = id_i;
    end else if (adv_i) begin
      addr_d = addr_width'(axi_next_addr(32'(addr_q), size_q, burst_q));
      // Holding at len on the final beat keeps a 256-beat burst from wrapping.
      if (!last_o) cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      prot_q  <= '0;
      burst_q <= '0;
      id_q    <= '0;
    end else begin
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      prot_q  <= prot_d;
      burst_q <= burst_d;
      id_q    <= id_d;
    end
  end

endmodule

// File: rtl/axi4_lite_burst_bridge.sv
// AXI4 burst to AXI4-Lite single-beat bridge.
// S_* ports face the AXI4 slot, M_* ports face the Lite peripheral.
// Each burst becomes LEN+1 Lite transfers; write responses merge into one B
// (worst response wins, WLAST misplacement forces SLVERR), read beats are
// re-tagged with ID and LAST. Write and read paths run independently.
//
// Write FSM  state   | meaning
//            W_IDLE  | accept AW burst descriptor
//            W_ADDR  | present Lite AW for current beat
//            W_DATA  | pass one W beat through to Lite W
//            W_RESP  | collect Lite B, merge, step beat
//            W_BRESP | present merged AXI4 B
// Read FSM   R_IDLE  | accept AR burst descriptor
//            R_ADDR  | present Lite AR for current beat
//            R_WAIT  | capture Lite R data/resp
//            R_OUT   | present AXI4 R beat with ID/LAST
module axi4_lite_burst_bridge
  import axi4_pkg::*;
#(
  parameter int data_width = 32,
  parameter int addr_width = 5,
  parameter int id_width   = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    S_AWVALID,
  output logic                    S_AWREADY,
  input  logic [addr_width-1:0]   S_AWADDR,
  input  logic [7:0]              S_AWLEN,
  input  logic [2:0]              S_AWSIZE,
  input  logic [1:0]              S_AWBURST,
  input  logic [2:0]              S_AWPROT,
  input  logic [id_width-1:0]     S_AWID,
  input  logic                    S_WVALID,
  output logic                    S_WREADY,
  input  logic [data_width-1:0]   S_WDATA,
  input  logic [data_width/8-1:0] S_WSTRB,
  input  logic                    S_WLAST,
  output logic                    S_BVALID,
  input  logic                    S_BREADY,
  output logic [1:0]              S_BRESP,
  output logic [id_width-1:0]     S_BID,
  input  logic                    S_ARVALID,
  output logic                    S_ARREADY,
  input  logic [addr_width-1:0]   S_ARADDR,
  input  logic [7:0]              S_ARLEN,
  input  logic [2:0]              S_ARSIZE,
  input  logic [1:0]              S_ARBURST,
  input  logic [2:0]              S_ARPROT,
  input  logic [id_width-1:0]     S_ARID,
  output logic                    S_RVALID,
  input  logic                    S_RREADY,
  output logic [data_width-1:0]   S_RDATA,
  output logic [1:0]              S_RRESP,
  output logic [id_width-1:0]     S_RID,
  output logic                    S_RLAST,
  output logic                    M_AWVALID,
  input  logic                    M_AWREADY,
  output logic [addr_width-1:0]   M_AWADDR,
  output logic [2:0]              M_AWPROT,
  output logic                    M_WVALID,
  input  logic                    M_WREADY,
  output logic [data_width-1:0]   M_WDATA,
  output logic [data_width/8-1:0] M_WSTRB,
  input  logic                    M_BVALID,
  output logic                    M_BREADY,
  input  logic [1:0]              M_BRESP,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  output logic [addr_width-1:0]   M_ARADDR,
  output logic [2:0]              M_ARPROT,
  input  logic                    M_RVALID,
  output logic                    M_RREADY,
  input  logic [data_width-1:0]   M_RDATA,
  input  logic [1:0]              M_RRESP
);

  localparam int strb_width = data_width / 8;

  wr_state_e             w_state_q, w_state_d;
  rd_state_e             r_state_q, r_state_d;
  logic                  werr_q, werr_d;
  logic [1:0]            bresp_acc_q, bresp_acc_d;
  logic [data_width-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  w_load, w_adv, w_last, r_load, r_adv, r_last;

  axi4_lite_burst_ctl #(.addr_width(addr_width), .id_width(id_width)) u_wr_ctl (
    .ACLK(ACLK), .ARESETn(ARESETn), .load_i(w_load), .adv_i(w_adv),
    .addr_i(S_AWADDR), .len_i(S_AWLEN), .size_i(S_AWSIZE), .burst_i(S_AWBURST),
    .prot_i(S_AWPROT), .id_i(S_AWID),
    .addr_o(M_AWADDR), .prot_o(M_AWPROT), .id_o(S_BID), .last_o(w_last)
  );

  axi4_lite_burst_ctl #(.addr_width(addr_width), .id_width(id_width)) u_rd_ctl (
    .ACLK(ACLK), .ARESETn(ARESETn), .load_i(r_load), .adv_i(r_adv),
    .addr_i(S_ARADDR), .len_i(S_ARLEN), .size_i(S_ARSIZE), .burst_i(S_ARBURST),
    .prot_i(S_ARPROT), .id_i(S_ARID),
    .addr_o(M_ARADDR), .prot_o(M_ARPROT), .id_o(S_RID), .last_o(r_last)
  );

  assign S_RDATA = rdata_q;
  assign S_RRESP = rresp_q;

  always_comb begin
    w_state_d   = w_state_q;
    werr_d      = werr_q;
    bresp_acc_d = bresp_acc_q;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    S_AWREADY   = 1'b0;
    S_WREADY    = 1'b0;
    S_BVALID    = 1'b0;
    S_BRESP     = RESP_OKAY;
    M_AWVALID   = 1'b0;
    M_WVALID    = 1'b0;
    M_WDATA     = '0;
    M_WSTRB     = '0;
    M_BREADY    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        S_AWREADY = 1'b1;
        if (S_AWVALID) begin
          w_load      = 1'b1;
          werr_d      = 1'b0;
          bresp_acc_d = RESP_OKAY;
          w_state_d   = W_ADDR;
        end
      end
      W_ADDR: begin
        M_AWVALID = 1'b1;
        if (M_AWREADY) w_state_d = W_DATA;
      end
      W_DATA: begin
        M_WVALID = S_WVALID;
        S_WREADY = M_WREADY;
        M_WDATA  = S_WDATA;
        M_WSTRB  = S_WSTRB;
        if (S_WVALID && M_WREADY) begin
          // A misplaced WLAST still forwards the beat but poisons the B response.
          if (S_WLAST != w_last) werr_d = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        M_BREADY = 1'b1;
        if (M_BVALID) begin
          if (M_BRESP > bresp_acc_q) bresp_acc_d = M_BRESP;
          w_adv     = 1'b1;
          w_state_d = w_last ? W_BRESP : W_ADDR;
        end
      end
      W_BRESP: begin
        S_BVALID = 1'b1;
        S_BRESP  = werr_q ? RESP_SLVERR : bresp_acc_q;
        if (S_BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    r_load    = 1'b0;
    r_adv     = 1'b0;
    S_ARREADY = 1'b0;
    S_RVALID  = 1'b0;
    S_RLAST   = 1'b0;
    M_ARVALID = 1'b0;
    M_RREADY  = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        S_ARREADY = 1'b1;
        if (S_ARVALID) begin
          r_load    = 1'b1;
          r_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        M_ARVALID = 1'b1;
        if (M_ARREADY) r_state_d = R_WAIT;
      end
      R_WAIT: begin
        M_RREADY = 1'b1;
        if (M_RVALID) begin
          rdata_d   = M_RDATA;
          rresp_d   = M_RRESP;
          r_state_d = R_OUT;
        end
      end
      R_OUT: begin
        S_RVALID = 1'b1;
        S_RLAST  = r_last;
        if (S_RREADY) begin
          r_adv     = 1'b1;
          r_state_d = r_last ? R_IDLE : R_ADDR;
        end
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      werr_q      <= 1'b0;
      bresp_acc_q <= RESP_OKAY;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      werr_q      <= werr_d;
      bresp_acc_q <= bresp_acc_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_burst_bridge.sv
module tb_axi4_lite_burst_bridge;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        S_AWVALID, S_AWREADY;
  logic [4:0]  S_AWADDR;
  logic [7:0]  S_AWLEN;
  logic [2:0]  S_AWSIZE;
  logic [1:0]  S_AWBURST;
  logic [2:0]  S_AWPROT;
  logic [3:0]  S_AWID;
  logic        S_WVALID, S_WREADY;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTRB;
  logic        S_WLAST;
  logic        S_BVALID, S_BREADY;
  logic [1:0]  S_BRESP;
  logic [3:0]  S_BID;
  logic        S_ARVALID, S_ARREADY;
  logic [4:0]  S_ARADDR;
  logic [7:0]  S_ARLEN;
  logic [2:0]  S_ARSIZE;
  logic [1:0]  S_ARBURST;
  logic [2:0]  S_ARPROT;
  logic [3:0]  S_ARID;
  logic        S_RVALID, S_RREADY;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic [3:0]  S_RID;
  logic        S_RLAST;
  logic        M_AWVALID, M_AWREADY;
  logic [4:0]  M_AWADDR;
  logic [2:0]  M_AWPROT;
  logic        M_WVALID, M_WREADY;
  logic [31:0] M_WDATA;
  logic [3:0]  M_WSTRB;
  logic        M_BVALID, M_BREADY;
  logic [1:0]  M_BRESP;
  logic        M_ARVALID, M_ARREADY;
  logic [4:0]  M_ARADDR;
  logic [2:0]  M_ARPROT;
  logic        M_RVALID, M_RREADY;
  logic [31:0] M_RDATA;
  logic [1:0]  M_RRESP;

  always #5 ACLK = ~ACLK;

  axi4_lite_burst_bridge #(.data_width(32), .addr_width(5), .id_width(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN),
    .S_AWSIZE(S_AWSIZE), .S_AWBURST(S_AWBURST), .S_AWPROT(S_AWPROT), .S_AWID(S_AWID),
    .S_WVALID(S_WVALID), .S_WREADY(S_WREADY), .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB),
    .S_WLAST(S_WLAST), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY), .S_BRESP(S_BRESP),
    .S_BID(S_BID), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY), .S_ARADDR(S_ARADDR),
    .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST), .S_ARPROT(S_ARPROT),
    .S_ARID(S_ARID), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY), .S_RDATA(S_RDATA),
    .S_RRESP(S_RRESP), .S_RID(S_RID), .S_RLAST(S_RLAST),
    .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_AWADDR(M_AWADDR), .M_AWPROT(M_AWPROT),
    .M_WVALID(M_WVALID), .M_WREADY(M_WREADY), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB),
    .M_BVALID(M_BVALID), .M_BREADY(M_BREADY), .M_BRESP(M_BRESP),
    .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR), .M_ARPROT(M_ARPROT),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: pushed when stimulus is planned, popped at handshakes.
  logic [7:0]  exp_aw[$];   // {prot, addr}
  logic [35:0] exp_w[$];    // {data, strb}
  logic [7:0]  exp_ar[$];   // {prot, addr}
  logic [5:0]  exp_b[$];    // {id, resp}
  logic [38:0] exp_r[$];    // {data, resp, id, last}
  logic [1:0]  bresp_seq[$];

  logic [31:0] slv_mem[8];
  logic [31:0] model_mem[8];
  logic [1:0]  slv_rresp = 2'b00;
  int          rbeats = 0;

  bit          b_pend = 1'b0, r_pend = 1'b0;
  logic [4:0]  slv_awaddr = '0;
  logic [31:0] slv_rdata = '0;
  logic [1:0]  slv_rr = '0, slv_br = '0;
  logic [7:0]  s_e8;
  logic [35:0] s_e36;
  logic [5:0]  s_e6;
  logic [38:0] s_e39;

  function automatic logic [31:0] wdata(input logic [3:0] id, input int i);
    return {16'hC0DE, id, 4'h0, 8'(i)};
  endfunction

  // Lite peripheral model plus upstream response monitor.
  initial begin
    M_AWREADY = 1'b1; M_WREADY = 1'b1; M_ARREADY = 1'b1;
    M_BVALID = 1'b0; M_BRESP = '0; M_RVALID = 1'b0; M_RDATA = '0; M_RRESP = '0;
    forever begin
      @(negedge ACLK);
      M_BVALID = b_pend; M_BRESP = slv_br;
      M_RVALID = r_pend; M_RDATA = slv_rdata; M_RRESP = slv_rr;
      #4;
      if (!ARESETn) begin
        b_pend = 1'b0; r_pend = 1'b0;
      end else begin
        if (M_AWVALID && M_AWREADY) begin
          slv_awaddr = M_AWADDR;
          checks++;
          if (exp_aw.size() == 0) begin
            errors++; $display("FAIL lite_aw unexpected addr=%h", M_AWADDR);
          end else begin
            s_e8 = exp_aw.pop_front();
            if ({M_AWPROT, M_AWADDR} !== s_e8) begin
              errors++; $display("FAIL lite_aw got prot/addr=%h required=%h", {M_AWPROT, M_AWADDR}, s_e8);
            end
          end
        end
        if (M_WVALID && M_WREADY) begin
          slv_mem[slv_awaddr[4:2]] = M_WDATA;
          slv_br = (bresp_seq.size() != 0) ? bresp_seq.pop_front() : 2'b00;
          b_pend = 1'b1;
          checks++;
          if (exp_w.size() == 0) begin
            errors++; $display("FAIL lite_w unexpected data=%h", M_WDATA);
          end else begin
            s_e36 = exp_w.pop_front();
            if ({M_WDATA, M_WSTRB} !== s_e36) begin
              errors++; $display("FAIL lite_w got data/strb=%h required=%h", {M_WDATA, M_WSTRB}, s_e36);
            end
          end
        end
        if (M_BVALID && M_BREADY) b_pend = 1'b0;
        if (M_ARVALID && M_ARREADY) begin
          slv_rdata = slv_mem[M_ARADDR[4:2]];
          slv_rr = slv_rresp;
          r_pend = 1'b1;
          checks++;
          if (exp_ar.size() == 0) begin
            errors++; $display("FAIL lite_ar unexpected addr=%h", M_ARADDR);
          end else begin
            s_e8 = exp_ar.pop_front();
            if ({M_ARPROT, M_ARADDR} !== s_e8) begin
              errors++; $display("FAIL lite_ar got prot/addr=%h required=%h", {M_ARPROT, M_ARADDR}, s_e8);
            end
          end
        end
        if (M_RVALID && M_RREADY) r_pend = 1'b0;
        if (S_BVALID && S_BREADY) begin
          checks++;
          if (exp_b.size() == 0) begin
            errors++; $display("FAIL axi_b unexpected id/resp=%h", {S_BID, S_BRESP});
          end else begin
            s_e6 = exp_b.pop_front();
            if ({S_BID, S_BRESP} !== s_e6) begin
              errors++; $display("FAIL axi_b got id/resp=%h required=%h", {S_BID, S_BRESP}, s_e6);
            end
          end
        end
        if (S_RVALID && S_RREADY) begin
          rbeats++;
          checks++;
          if (exp_r.size() == 0) begin
            errors++; $display("FAIL axi_r unexpected data=%h", S_RDATA);
          end else begin
            s_e39 = exp_r.pop_front();
            if ({S_RDATA, S_RRESP, S_RID, S_RLAST} !== s_e39) begin
              errors++; $display("FAIL axi_r got data/resp/id/last=%h required=%h",
                                 {S_RDATA, S_RRESP, S_RID, S_RLAST}, s_e39);
            end
          end
        end
      end
    end
  end

  task automatic wait_ready(input int sel, input string nm);
    logic rdy;
    for (int i = 0; i < 200; i++) begin
      #4;
      rdy = (sel == 0) ? S_AWREADY : (sel == 1) ? S_WREADY : S_ARREADY;
      if (rdy) return;
      @(negedge ACLK);
    end
    checks++; errors++;
    $display("FAIL %s timeout got ready=0 required=1", nm);
  endtask

  task automatic exp_write(input logic [4:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input logic [2:0] prot,
                           input logic [1:0] resp);
    logic [4:0] a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      exp_aw.push_back({prot, a});
      exp_w.push_back({wdata(id, i), 4'hF});
      model_mem[a[4:2]] = wdata(id, i);
      if (burst == 2'b01 || burst == 2'b10) a = a + 5'(32'd1 << size);
    end
    exp_b.push_back({id, resp});
  endtask

  task automatic exp_read(input logic [4:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input logic [2:0] prot,
                          input logic [1:0] resp);
    logic [4:0] a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      exp_ar.push_back({prot, a});
      exp_r.push_back({model_mem[a[4:2]], resp, id, (i == int'(len))});
      if (burst == 2'b01 || burst == 2'b10) a = a + 5'(32'd1 << size);
    end
  endtask

  task automatic drive_aw(input logic [4:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input logic [2:0] prot);
    @(negedge ACLK);
    S_AWVALID = 1'b1; S_AWADDR = addr; S_AWLEN = len; S_AWSIZE = size;
    S_AWBURST = burst; S_AWID = id; S_AWPROT = prot;
    wait_ready(0, "aw_ready");
    @(negedge ACLK);
    S_AWVALID = 1'b0;
    checks++;
    if (S_AWREADY !== 1'b0) begin
      errors++; $display("FAIL awready_after_accept got=%b required=0", S_AWREADY);
    end
  endtask

  // Called at a negedge; bad = beat index whose WLAST is inverted (-1 for none).
  task automatic drive_w(input logic [7:0] len, input logic [3:0] id, input int bad);
    for (int i = 0; i <= int'(len); i++) begin
      S_WVALID = 1'b1; S_WDATA = wdata(id, i); S_WSTRB = 4'hF;
      S_WLAST = ((i == int'(len)) != (i == bad));
      wait_ready(1, "w_ready");
      @(negedge ACLK);
    end
    S_WVALID = 1'b0; S_WLAST = 1'b0;
  endtask

  task automatic drive_ar(input logic [4:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input logic [2:0] prot);
    @(negedge ACLK);
    S_ARVALID = 1'b1; S_ARADDR = addr; S_ARLEN = len; S_ARSIZE = size;
    S_ARBURST = burst; S_ARID = id; S_ARPROT = prot;
    wait_ready(2, "ar_ready");
    @(negedge ACLK);
    S_ARVALID = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 2000; i++) begin
      @(negedge ACLK);
      if (exp_aw.size() == 0 && exp_w.size() == 0 && exp_ar.size() == 0 &&
          exp_b.size() == 0 && exp_r.size() == 0) return;
    end
    checks++; errors++;
    $display("FAIL %s drain timeout got pending b=%0d r=%0d required=0", nm, exp_b.size(), exp_r.size());
  endtask

  task automatic test_reset();
    repeat (3) @(negedge ACLK);
    checks++;
    if ({S_AWREADY, S_ARREADY, S_WREADY, S_BVALID, S_RVALID, S_RLAST, M_AWVALID, M_WVALID,
         M_BREADY, M_ARVALID, M_RREADY} !== 11'b110_0000_0000) begin
      errors++; $display("FAIL reset_ctrl got=%b required=11000000000",
        {S_AWREADY, S_ARREADY, S_WREADY, S_BVALID, S_RVALID, S_RLAST, M_AWVALID, M_WVALID,
         M_BREADY, M_ARVALID, M_RREADY});
    end
    checks++;
    if ({S_RDATA, S_BRESP, M_AWADDR, M_ARADDR, M_WDATA} !== '0) begin
      errors++; $display("FAIL reset_data got rdata=%h awaddr=%h araddr=%h required=0",
                         S_RDATA, M_AWADDR, M_ARADDR);
    end
    ARESETn = 1'b1;
  endtask

  task automatic test_write_incr();
    exp_write(5'h04, 8'd2, 3'd2, 2'b01, 4'h3, 3'b010, 2'b00);
    drive_aw(5'h04, 8'd2, 3'd2, 2'b01, 4'h3, 3'b010);
    drive_w(8'd2, 4'h3, -1);
    drain("write_incr");
  endtask

  task automatic test_read_wrap_addr();
    exp_read(5'h1C, 8'd1, 3'd2, 2'b01, 4'h7, 3'b001, 2'b00);
    drive_ar(5'h1C, 8'd1, 3'd2, 2'b01, 4'h7, 3'b001);
    drain("read_wrap_addr");
  endtask

  task automatic test_write_fixed();
    bresp_seq = '{2'b00, 2'b10, 2'b00, 2'b11};
    exp_write(5'h10, 8'd3, 3'd2, 2'b00, 4'hA, 3'b000, 2'b11);
    drive_aw(5'h10, 8'd3, 3'd2, 2'b00, 4'hA, 3'b000);
    drive_w(8'd3, 4'hA, -1);
    drain("write_fixed");
    exp_read(5'h10, 8'd0, 3'd2, 2'b00, 4'h1, 3'b000, 2'b00);
    drive_ar(5'h10, 8'd0, 3'd2, 2'b00, 4'h1, 3'b000);
    drain("fixed_readback");
  endtask

  task automatic test_bad_wlast();
    exp_write(5'h08, 8'd1, 3'd2, 2'b01, 4'h6, 3'b000, 2'b10);
    drive_aw(5'h08, 8'd1, 3'd2, 2'b01, 4'h6, 3'b000);
    drive_w(8'd1, 4'h6, 0);
    drain("bad_wlast");
  endtask

  task automatic test_bresp_merge();
    bresp_seq = '{2'b01, 2'b00, 2'b01};
    exp_write(5'h00, 8'd2, 3'd2, 2'b10, 4'h2, 3'b100, 2'b01);
    drive_aw(5'h00, 8'd2, 3'd2, 2'b10, 4'h2, 3'b100);
    drive_w(8'd2, 4'h2, -1);
    drain("bresp_merge");
  endtask

  task automatic test_concurrent_stall();
    logic [31:0] held;
    bit seen = 1'b0;
    S_RREADY = 1'b0;
    slv_rresp = 2'b01;
    exp_write(5'h14, 8'd0, 3'd2, 2'b01, 4'h9, 3'b000, 2'b00);
    exp_read(5'h00, 8'd3, 3'd2, 2'b01, 4'h5, 3'b011, 2'b01);
    @(negedge ACLK);
    S_AWVALID = 1'b1; S_AWADDR = 5'h14; S_AWLEN = 8'd0; S_AWSIZE = 3'd2;
    S_AWBURST = 2'b01; S_AWID = 4'h9; S_AWPROT = 3'b000;
    S_ARVALID = 1'b1; S_ARADDR = 5'h00; S_ARLEN = 8'd3; S_ARSIZE = 3'd2;
    S_ARBURST = 2'b01; S_ARID = 4'h5; S_ARPROT = 3'b011;
    wait_ready(0, "conc_aw_ready");
    checks++;
    if (S_ARREADY !== 1'b1) begin
      errors++; $display("FAIL conc_arready got=%b required=1", S_ARREADY);
    end
    @(negedge ACLK);
    S_AWVALID = 1'b0; S_ARVALID = 1'b0;
    drive_w(8'd0, 4'h9, -1);
    for (int i = 0; i < 50 && !seen; i++) begin
      if (S_RVALID) seen = 1'b1; else @(negedge ACLK);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL conc_rvalid timeout got=0 required=1");
    end
    held = S_RDATA;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      checks++;
      if (S_RVALID !== 1'b1 || S_RDATA !== held) begin
        errors++; $display("FAIL r_stall got valid=%b data=%h required valid=1 data=%h",
                           S_RVALID, S_RDATA, held);
      end
    end
    S_RREADY = 1'b1;
    drain("concurrent");
    slv_rresp = 2'b00;
  endtask

  task automatic test_reset_mid_read();
    bit hit = 1'b0;
    rbeats = 0;
    exp_read(5'h00, 8'd3, 3'd2, 2'b01, 4'hC, 3'b000, 2'b00);
    drive_ar(5'h00, 8'd3, 3'd2, 2'b01, 4'hC, 3'b000);
    for (int i = 0; i < 50 && !hit; i++) begin
      if (rbeats >= 1) hit = 1'b1; else @(negedge ACLK);
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL reset_mid first beat timeout got=0 required=1");
    end
    ARESETn = 1'b0;
    @(negedge ACLK);
    checks++;
    if ({S_AWREADY, S_ARREADY, S_BVALID, S_RVALID, M_AWVALID, M_WVALID, M_ARVALID} !== 7'b1100000) begin
      errors++; $display("FAIL reset_mid got=%b required=1100000",
        {S_AWREADY, S_ARREADY, S_BVALID, S_RVALID, M_AWVALID, M_WVALID, M_ARVALID});
    end
    ARESETn = 1'b1;
    exp_ar.delete();
    exp_r.delete();
    exp_read(5'h08, 8'd1, 3'd2, 2'b01, 4'hE, 3'b000, 2'b00);
    drive_ar(5'h08, 8'd1, 3'd2, 2'b01, 4'hE, 3'b000);
    drain("after_reset_read");
    exp_write(5'h18, 8'd0, 3'd2, 2'b01, 4'h4, 3'b000, 2'b00);
    drive_aw(5'h18, 8'd0, 3'd2, 2'b01, 4'h4, 3'b000);
    drive_w(8'd0, 4'h4, -1);
    drain("after_reset_write");
  endtask

  initial begin
    S_AWVALID = 0; S_AWADDR = 0; S_AWLEN = 0; S_AWSIZE = 0; S_AWBURST = 0; S_AWPROT = 0; S_AWID = 0;
    S_WVALID = 0; S_WDATA = 0; S_WSTRB = 0; S_WLAST = 0; S_BREADY = 1;
    S_ARVALID = 0; S_ARADDR = 0; S_ARLEN = 0; S_ARSIZE = 0; S_ARBURST = 0; S_ARPROT = 0; S_ARID = 0;
    S_RREADY = 1;
    for (int i = 0; i < 8; i++) begin
      slv_mem[i] = 32'h1111_1111 * (i + 1);
      model_mem[i] = 32'h1111_1111 * (i + 1);
    end
    test_reset();
    test_write_incr();
    test_read_wrap_addr();
    test_write_fixed();
    test_bad_wlast();
    test_bresp_merge();
    test_concurrent_stall();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
